// File: rtl/gray_ptr_cnt_if.sv
// Signal bundle for one gray_ptr_cnt instance: local count controls, the remote
// Gray pointer input and every count/pointer output.
interface gray_ptr_cnt_if #(
  parameter int WIDTH = 8
);
  // inc_i/clr_i are per-cycle requests sampled on every rising edge; there is no ready.
  logic             inc_i;
  logic             clr_i;
  logic [WIDTH-1:0] rmt_gray_i;
  logic [WIDTH-1:0] bin_o;
  logic [WIDTH-1:0] gray_o;
  logic             wrap_o;
  logic             sat_o;
  logic [WIDTH-1:0] rmt_bin_o;
  logic [WIDTH-1:0] diff_o;

  modport master (
    output inc_i, clr_i, rmt_gray_i,
    input  bin_o, gray_o, wrap_o, sat_o, rmt_bin_o, diff_o
  );

  modport slave (
    input  inc_i, clr_i, rmt_gray_i,
    output bin_o, gray_o, wrap_o, sat_o, rmt_bin_o, diff_o
  );
endinterface

// File: rtl/gray_ptr_cnt.sv
// Binary/Gray pointer counter with a registered Gray copy, wrap/saturate control,
// a remote Gray pointer synchroniser with decode, and local-minus-remote distance.
module gray_ptr_cnt #(
  parameter int DLY         = 1,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_MODE   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] rmt_gray_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic             sat_o,
  output logic [WIDTH-1:0] rmt_bin_o,
  output logic [WIDTH-1:0] diff_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (DLY < 0 || WIDTH < 2 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      WRAP_MODE < 0 || WRAP_MODE > 1) begin : g_bad_param
    $error("gray_ptr_cnt: parameter out of legal range");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] rmt_bin;
  logic             term_cnt;

  assign term_cnt = &cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (!term_cnt) begin
        cnt_d = cnt_q + ONE;
      end else if (WRAP_MODE == 0) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end
    end
    // Gray copy is built from the next count so it lands on the same edge as cnt_q.
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  // Plain flop chain; clr_i deliberately has no effect on it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= rmt_gray_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Bit i of the binary value is the XOR of Gray bits WIDTH-1 down to i.
  always_comb begin
    rmt_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rmt_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  assign bin_o     = cnt_q;
  assign gray_o    = gray_q;
  assign wrap_o    = wrap_q;
  assign sat_o     = (WRAP_MODE == 1) && term_cnt;
  assign rmt_bin_o = rmt_bin;
  assign diff_o    = cnt_q - rmt_bin;

endmodule

// File: tb/tb_gray_ptr_cnt.sv
// Directed table plus corner-case sequences and a random run for gray_ptr_cnt.
module tb_gray_ptr_cnt;

  typedef struct {
    logic       inc;
    logic       clr;
    logic [3:0] rmt;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic [3:0] rbin;
    logic [3:0] diff;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gray_ptr_cnt_if #(.WIDTH(4)) bus_a ();
  gray_ptr_cnt_if #(.WIDTH(4)) bus_b ();
  gray_ptr_cnt_if #(.WIDTH(8)) bus_c ();

  gray_ptr_cnt #(.DLY(1), .WIDTH(4), .SYNC_STAGES(2), .WRAP_MODE(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .inc_i(bus_a.inc_i), .clr_i(bus_a.clr_i),
    .rmt_gray_i(bus_a.rmt_gray_i), .bin_o(bus_a.bin_o), .gray_o(bus_a.gray_o),
    .wrap_o(bus_a.wrap_o), .sat_o(bus_a.sat_o), .rmt_bin_o(bus_a.rmt_bin_o),
    .diff_o(bus_a.diff_o)
  );

  gray_ptr_cnt #(.DLY(1), .WIDTH(4), .SYNC_STAGES(2), .WRAP_MODE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .inc_i(bus_b.inc_i), .clr_i(bus_b.clr_i),
    .rmt_gray_i(bus_b.rmt_gray_i), .bin_o(bus_b.bin_o), .gray_o(bus_b.gray_o),
    .wrap_o(bus_b.wrap_o), .sat_o(bus_b.sat_o), .rmt_bin_o(bus_b.rmt_bin_o),
    .diff_o(bus_b.diff_o)
  );

  gray_ptr_cnt #(.DLY(1), .WIDTH(8), .SYNC_STAGES(2), .WRAP_MODE(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .inc_i(bus_c.inc_i), .clr_i(bus_c.clr_i),
    .rmt_gray_i(bus_c.rmt_gray_i), .bin_o(bus_c.bin_o), .gray_o(bus_c.gray_o),
    .wrap_o(bus_c.wrap_o), .sat_o(bus_c.sat_o), .rmt_bin_o(bus_c.rmt_bin_o),
    .diff_o(bus_c.diff_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written Gray sequence for 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  vec_t vecs[$];

  task automatic add(input logic inc, input logic clr, input logic [3:0] rmt,
                     input logic [3:0] bin, input logic wrap,
                     input logic [3:0] rbin, input logic [3:0] diff);
    vec_t v;
    v.inc = inc; v.clr = clr; v.rmt = rmt; v.bin = bin; v.gray = gray_tab[bin];
    v.wrap = wrap; v.rbin = rbin; v.diff = diff;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] model;
    logic [7:0] prev_gray;
    logic       exp_wrap;
    logic [3:0] eb;

    bus_a.inc_i = 0; bus_a.clr_i = 0; bus_a.rmt_gray_i = '0;
    bus_b.inc_i = 0; bus_b.clr_i = 0; bus_b.rmt_gray_i = '0;
    bus_c.inc_i = 0; bus_c.clr_i = 0; bus_c.rmt_gray_i = '0;

    // 16 increments through a full wrap, then one idle cycle.
    for (int i = 1; i <= 15; i++) add(1, 0, 4'h0, 4'(i), 0, 4'h0, 4'(i));
    add(1, 0, 4'h0, 4'h0, 1, 4'h0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0);
    // Count to 9, then clear and increment together.
    for (int i = 1; i <= 9; i++) add(1, 0, 4'h0, 4'(i), 0, 4'h0, 4'(i));
    add(1, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0);
    // Count to 7, change the remote pointer to Gray 0110 (binary 4).
    for (int i = 1; i <= 7; i++) add(1, 0, 4'h0, 4'(i), 0, 4'h0, 4'(i));
    add(0, 0, 4'h6, 4'h7, 0, 4'h0, 4'h7);
    add(0, 0, 4'h6, 4'h7, 0, 4'h4, 4'h3);
    add(0, 1, 4'h6, 4'h0, 0, 4'h4, 4'hC);
    add(1, 0, 4'h6, 4'h1, 0, 4'h4, 4'hD);
    add(1, 0, 4'h6, 4'h2, 0, 4'h4, 4'hE);

    // Reset asserted asynchronously; outputs must be zero without a clock edge.
    #2;
    chk("rst_bin", 32'(bus_a.bin_o), 32'h0);
    chk("rst_gray", 32'(bus_a.gray_o), 32'h0);
    chk("rst_wrap", 32'(bus_a.wrap_o), 32'h0);
    chk("rst_rmt_bin", 32'(bus_a.rmt_bin_o), 32'h0);
    chk("rst_diff", 32'(bus_a.diff_o), 32'h0);
    repeat (3) @(posedge clk);
    #4 rst = 0;
    #2;

    foreach (vecs[k]) begin
      bus_a.inc_i = vecs[k].inc;
      bus_a.clr_i = vecs[k].clr;
      bus_a.rmt_gray_i = vecs[k].rmt;
      tick();
      chk($sformatf("vec%0d_bin", k), 32'(bus_a.bin_o), 32'(vecs[k].bin));
      chk($sformatf("vec%0d_gray", k), 32'(bus_a.gray_o), 32'(vecs[k].gray));
      chk($sformatf("vec%0d_wrap", k), 32'(bus_a.wrap_o), 32'(vecs[k].wrap));
      chk($sformatf("vec%0d_sat", k), 32'(bus_a.sat_o), 32'h0);
      chk($sformatf("vec%0d_rmt_bin", k), 32'(bus_a.rmt_bin_o), 32'(vecs[k].rbin));
      chk($sformatf("vec%0d_diff", k), 32'(bus_a.diff_o), 32'(vecs[k].diff));
    end
    bus_a.inc_i = 0;

    // Saturating instance: 20 increments, holds at 15 / Gray 1000.
    bus_b.inc_i = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      eb = (i >= 15) ? 4'hF : 4'(i);
      chk($sformatf("sat%0d_bin", i), 32'(bus_b.bin_o), 32'(eb));
      chk($sformatf("sat%0d_gray", i), 32'(bus_b.gray_o), 32'(gray_tab[eb]));
      chk($sformatf("sat%0d_sat", i), 32'(bus_b.sat_o), (i >= 15) ? 32'h1 : 32'h0);
      chk($sformatf("sat%0d_wrap", i), 32'(bus_b.wrap_o), 32'h0);
    end

    // Bring dut_a to 15, then reset between edges while a wrap is about to be taken.
    bus_a.inc_i = 1;
    repeat (13) tick();
    chk("pre_rst_bin", 32'(bus_a.bin_o), 32'hF);
    #3 rst = 1;
    #1;
    chk("arst_bin", 32'(bus_a.bin_o), 32'h0);
    chk("arst_gray", 32'(bus_a.gray_o), 32'h0);
    chk("arst_wrap", 32'(bus_a.wrap_o), 32'h0);
    chk("arst_rmt_bin", 32'(bus_a.rmt_bin_o), 32'h0);
    chk("arst_diff", 32'(bus_a.diff_o), 32'h0);
    chk("arst_sat_b", 32'(bus_b.sat_o), 32'h0);
    chk("arst_bin_b", 32'(bus_b.bin_o), 32'h0);
    #2 rst = 0;
    tick();
    chk("rel_bin", 32'(bus_a.bin_o), 32'h1);
    chk("rel_gray", 32'(bus_a.gray_o), 32'h1);
    chk("rel_wrap", 32'(bus_a.wrap_o), 32'h0);
    chk("rel_rmt_bin", 32'(bus_a.rmt_bin_o), 32'h0);
    bus_a.inc_i = 0;
    tick();
    chk("rel2_wrap", 32'(bus_a.wrap_o), 32'h0);
    chk("rel2_rmt_bin", 32'(bus_a.rmt_bin_o), 32'h4);
    chk("rel2_diff", 32'(bus_a.diff_o), 32'hD);
    tick();
    chk("rel3_wrap", 32'(bus_a.wrap_o), 32'h0);

    // Random inc/clr against a behavioural model on the 8-bit instance.
    model = 8'h00;
    prev_gray = bus_c.gray_o;
    chk("rnd_start_bin", 32'(bus_c.bin_o), 32'h0);
    for (int c = 0; c < 10000; c++) begin
      bus_c.inc_i = 1'($urandom_range(0, 1));
      bus_c.clr_i = ($urandom_range(0, 15) == 0);
      exp_wrap = !bus_c.clr_i && bus_c.inc_i && (model == 8'hFF);
      if (bus_c.clr_i) model = 8'h00;
      else if (bus_c.inc_i) model = model + 8'h01;
      tick();
      chk("rnd_bin", 32'(bus_c.bin_o), 32'(model));
      chk("rnd_gray", 32'(bus_c.gray_o), 32'(model ^ (model >> 1)));
      chk("rnd_wrap", 32'(bus_c.wrap_o), 32'(exp_wrap));
      if (!bus_c.clr_i) chk("rnd_gray_step", ($countones(bus_c.gray_o ^ prev_gray) <= 1) ? 32'h1 : 32'h0, 32'h1);
      prev_gray = bus_c.gray_o;
    end
    bus_c.inc_i = 0;
    bus_c.clr_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_ptr_cnt.md
GRAY_PTR_CNT -- requirements
Module: gray_ptr_cnt

Interface
REQ-001 The block SHALL have these parameters:
- DLY, default 1, simulation-only register update delay; no effect on synthesis.
- WIDTH, default 8, counter and pointer width; legal range 2..32.
- SYNC_STAGES, default 2, synchroniser depth for the remote pointer; legal range 2..4.
- WRAP_MODE, default 0; 0 = wrap at terminal count, 1 = saturate at terminal count.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk_i, input, 1, single clock for all registers.
- rst_i, input, 1, asynchronous active-high reset.
- inc_i, input, 1, increment request, sampled on the rising edge of clk_i.
- clr_i, input, 1, synchronous clear.
- rmt_gray_i, input, WIDTH, Gray-coded pointer from another clock domain; asynchronous to clk_i.
- bin_o, output, WIDTH, local binary count (registered).
- gray_o, output, WIDTH, Gray code of bin_o (registered).
- wrap_o, output, 1, one-cycle pulse when the count wraps.
- sat_o, output, 1, level, high while the count is held at terminal count.
- rmt_bin_o, output, WIDTH, synchronised remote pointer, decoded to binary.
- diff_o, output, WIDTH, (bin_o - rmt_bin_o) mod 2^WIDTH.

REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL hold a WIDTH-bit binary register cnt; bin_o SHALL equal cnt.

REQ-005 gray_o SHALL be a separate register loaded with next_cnt ^ (next_cnt >> 1) on the same edge that loads cnt.
- gray_o is therefore glitch-free and exactly aligned with bin_o.
- gray_o SHALL never be combinationally derived from cnt.

REQ-006 Update priority per rising edge SHALL be clr_i > inc_i > hold.

REQ-007 With clr_i=1, the block SHALL load cnt=0 and gray_o=0, and wrap_o SHALL be 0 on the next cycle.

REQ-008 With clr_i=0 and inc_i=1 and cnt below terminal count (all ones), the block SHALL set cnt=cnt+1.
- Latency from the inc_i edge to the new value on bin_o and gray_o is 1 cycle.

REQ-009 WRAP_MODE=0, at terminal count with inc_i=1: cnt SHALL go to 0, and wrap_o SHALL be high for exactly the following cycle.

REQ-010 WRAP_MODE=1, at terminal count: inc_i SHALL be ignored, cnt SHALL hold, and wrap_o SHALL stay 0.

REQ-011 sat_o SHALL be 1 exactly when WRAP_MODE=1 and cnt is all ones; sat_o SHALL be 0 whenever WRAP_MODE=0.

REQ-012 On consecutive cycles, gray_o SHALL change in at most one bit.
- This holds across the wrap from all ones to 0.
- A clear is the only permitted exception.

REQ-013 rmt_gray_i SHALL pass through a chain of SYNC_STAGES flops with no logic between stages.
- Only the last stage output SHALL be decoded.

REQ-014 Decode SHALL follow b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i], down to i=0.
- rmt_bin_o is combinational from the last synchroniser stage.
- Latency from a stable rmt_gray_i to rmt_bin_o is SYNC_STAGES cycles.

REQ-015 diff_o SHALL be combinational modulo-2^WIDTH subtraction of registered values; it needs no extra bit and has no sign.

REQ-016 clr_i SHALL NOT affect the synchroniser chain.

Reset
REQ-017 While rst_i=1, the following SHALL be 0 immediately, independent of clk_i:
- cnt, gray_o, wrap_o, sat_o, all synchroniser stages, rmt_bin_o, diff_o.

REQ-018 Deassertion of rst_i SHALL take effect at the first clk_i edge after release.
- inc_i on that edge SHALL be honoured.

REQ-019 Reset asserted mid-count or mid-wrap-pulse SHALL cancel any pending wrap_o pulse; no residual pulse SHALL follow release.

Verification
REQ-020 WIDTH=4, WRAP_MODE=0, inc_i held high for 16 cycles from reset -> the bench SHALL check:
- bin_o steps 0,1,...,15,0.
- gray_o steps 0000,0001,0011,0010,...,1000,0000.
- wrap_o is high for exactly one cycle, coincident with bin_o=0.

REQ-021 WIDTH=4, WRAP_MODE=1, 20 increments -> the bench SHALL check:
- bin_o stops at 15 and gray_o stops at 1000.
- sat_o=1 from the cycle bin_o reaches 15.
- wrap_o is never asserted.

REQ-022 clr_i and inc_i both high at bin_o=9 -> the bench SHALL check that the next cycle shows bin_o=0, gray_o=0, and wrap_o=0.

REQ-023 SYNC_STAGES=2, rmt_gray_i changed from 0000 to 0110 with bin_o=7 held -> the bench SHALL check:
- rmt_bin_o=4 and diff_o=3 appear exactly 2 cycles later.
- With bin_o=2 and rmt_bin_o=4, diff_o=14.

REQ-024 rst_i pulsed asynchronously between clock edges while bin_o=15 with a wrap pending -> the bench SHALL check:
- All outputs are 0 before the next edge.
- There is no wrap_o pulse after release.

REQ-025 Random inc_i and clr_i for 10k cycles, WIDTH=8 -> the bench SHALL check every cycle:
- Model match on bin_o.
- gray_o equals bin_o^(bin_o>>1).
- Single-bit gray_o change except on clr_i.
